// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sw_pkg
// Description : Shared constants for the slide-switch conditioning stage.
//               Holds the board switch width, clock rate and debounce time,
//               plus the short debounce length used in simulation.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    localparam int SW_WIDTH          = 16;
    localparam int CLK_HZ            = 100_000_000;
    localparam int DEBOUNCE_MS       = 10;
    localparam int SIM_STABLE_CYCLES = 4;

    // Number of clk cycles spanning a given number of milliseconds.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int BOARD_STABLE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage : sw_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Single-bit switch conditioner. Two-flop synchronizer, a
//               stability counter, the clean output flop and registered
//               one-cycle rise/fall pulses.
// Ports       : clk      - system clock
//               rst      - asynchronous active-high reset
//               raw_i    - raw switch pin, asynchronous to clk
//               clean_o  - debounced switch level
//               rise_o   - one-cycle pulse when clean_o goes 0 -> 1
//               fall_o   - one-cycle pulse when clean_o goes 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit #(
    parameter int STABLE_CYCLES = sw_pkg::SIM_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    // Terminal count: the toggle happens on the edge that would otherwise
    // advance the counter to STABLE_CYCLES, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q == clean_q) begin
            // Any return to the clean level discards progress (glitch).
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            clean_d = ~clean_q;
            // Pulses are registered alongside clean_q so they line up
            // with the first cycle the new clean value is visible.
            rise_d  = ~clean_q;
            fall_d  = clean_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Conditions the board slide switches: synchronizes and
//               debounces every bit independently and provides per-bit
//               one-cycle rise/fall pulses for downstream sequential logic.
// Ports       : clk       - system clock (100 MHz on board)
//               rst       - asynchronous active-high reset
//               SW_raw    - raw switch pins, asynchronous to clk
//               SW_clean  - debounced, registered switch word
//               SW_rise   - per-bit one-cycle pulse on clean 0 -> 1
//               SW_fall   - per-bit one-cycle pulse on clean 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import sw_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = BOARD_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SW_raw,
    output logic [WIDTH-1:0] SW_clean,
    output logic [WIDTH-1:0] SW_rise,
    output logic [WIDTH-1:0] SW_fall
);

    // Bits share nothing but clock and reset.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_debounce_bit (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (SW_raw[i]),
            .clean_o (SW_clean[i]),
            .rise_o  (SW_rise[i]),
            .fall_o  (SW_fall[i])
        );
    end : g_bit

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed, self-checking bench for switch_debouncer with a
//               4-cycle debounce length. Stimulus changes 1 ns after a rising
//               edge, so the next edge is the first one to sample it; outputs
//               are checked 1 ns after edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int W  = 16;
    localparam int SC = sw_pkg::SIM_STABLE_CYCLES;
    localparam int LAT = 2 + SC;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;

    int n_vec = 0;
    int n_err = 0;

    switch_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SW_raw   (sw_raw),
        .SW_clean (sw_clean),
        .SW_rise  (sw_rise),
        .SW_fall  (sw_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold current input for n edges; clean must stay put with no pulses.
    task automatic hold(input int n, input logic [W-1:0] c, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            check_vec({tag, "_clean"}, sw_clean, c);
            check_vec({tag, "_rise"},  sw_rise,  '0);
            check_vec({tag, "_fall"},  sw_fall,  '0);
        end
    endtask

    // Apply a new raw word and check the clean word flips exactly LAT edges later.
    task automatic step(input logic [W-1:0] nv, input logic [W-1:0] old_c,
                        input logic [W-1:0] new_c, input string tag);
        sw_raw = nv;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT) begin
                check_vec({tag, "_wait_clean"}, sw_clean, old_c);
                check_vec({tag, "_wait_rise"},  sw_rise,  '0);
                check_vec({tag, "_wait_fall"},  sw_fall,  '0);
            end else begin
                check_vec({tag, "_clean"}, sw_clean, new_c);
                check_vec({tag, "_rise"},  sw_rise,  new_c & ~old_c);
                check_vec({tag, "_fall"},  sw_fall,  old_c & ~new_c);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = '0;

        // 1. Reset then idle
        #1;
        check_vec("rst_clean", sw_clean, '0);
        check_vec("rst_rise",  sw_rise,  '0);
        check_vec("rst_fall",  sw_fall,  '0);
        repeat (3) tick();
        rst = 1'b0;
        hold(20, 16'h0000, "idle");

        // 2. Clean step on bit 0, then back low
        step(16'h0001, 16'h0000, 16'h0001, "step_up");
        hold(2, 16'h0001, "step_hold");
        step(16'h0000, 16'h0001, 16'h0000, "step_dn");
        hold(2, 16'h0000, "step_idle");

        // 3a. 3-cycle glitch on bit 3 is rejected
        sw_raw = 16'h0008;
        hold(3, 16'h0000, "glitch_hi");
        sw_raw = 16'h0000;
        hold(10, 16'h0000, "glitch_lo");

        // 3b. 5-cycle pulse on bit 3 is accepted, then falls 6 edges after low
        sw_raw = 16'h0008;
        hold(5, 16'h0000, "pulse_hi");
        sw_raw = 16'h0000;
        tick();
        check_vec("pulse_rise_clean", sw_clean, 16'h0008);
        check_vec("pulse_rise",       sw_rise,  16'h0008);
        check_vec("pulse_rise_fall",  sw_fall,  16'h0000);
        hold(4, 16'h0008, "pulse_mid");
        tick();
        check_vec("pulse_fall_clean", sw_clean, 16'h0000);
        check_vec("pulse_fall_rise",  sw_rise,  16'h0000);
        check_vec("pulse_fall",       sw_fall,  16'h0008);
        hold(3, 16'h0000, "pulse_idle");

        // 4. Walking one, each value held 10 cycles
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] nv;
            logic [W-1:0] pv;
            nv = 16'h0001 << i;
            pv = (i == 0) ? 16'h0000 : (16'h0001 << (i - 1));
            step(nv, pv, nv, "walk");
            hold(4, nv, "walk_hold");
        end

        // 5. All bits at once
        step(16'h0000, 16'h8000, 16'h0000, "all_clr");
        hold(4, 16'h0000, "all_idle");
        step(16'hFFFF, 16'h0000, 16'hFFFF, "all_set");

        // 6. Asynchronous reset mid-cycle, then full re-debounce
        hold(3, 16'hFFFF, "pre_rst");
        #3;
        rst = 1'b1;
        #1;
        check_vec("async_rst_clean", sw_clean, '0);
        check_vec("async_rst_rise",  sw_rise,  '0);
        check_vec("async_rst_fall",  sw_fall,  '0);
        tick();
        check_vec("in_rst_clean", sw_clean, '0);
        rst = 1'b0;
        step(16'hFFFF, 16'h0000, 16'hFFFF, "post_rst");
        hold(2, 16'hFFFF, "post_rst_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_switch_debouncer
`default_nettype wire

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the board slide switches.
- Synchronizes each raw, asynchronous SW pin into the clk domain, debounces it, and presents a clean 16-bit switch word to the switch-to-LED stage.
- Also produces one-cycle rise and fall pulses per bit, so later sequential labs can react to switch edges.
- Sits between the top-level SW pins and the switch/LED logic.

Parameters:
- WIDTH, 16, number of switch bits handled.
- STABLE_CYCLES, 1_000_000, consecutive clk cycles a synchronized input must differ from the clean value before the clean value flips (10 ms at 100 MHz). Legal range is 1 or greater; benches use 4.
- CNT_W, $clog2(STABLE_CYCLES+1), width of each per-bit stability counter. Derived; do not override.

Ports:
- clk  input  1  system clock, 100 MHz on board.
- rst  input  1  reset, asynchronous, active-high.
- SW_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- SW_clean  output  WIDTH  debounced, registered switch word.
- SW_rise  output  WIDTH  one-cycle pulse on the cycle SW_clean[i] goes 0 to 1.
- SW_fall  output  WIDTH  one-cycle pulse on the cycle SW_clean[i] goes 1 to 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While rst=1, all synchronizer flops, counters, SW_clean, SW_rise and SW_fall are 0, immediately and without waiting for clk.
  - After rst deasserts, a switch held high therefore reports as a rise once it is debounced. This is intended.
- Synchronizer: each bit passes through two flops, s1 then s2. Only s2 feeds the debounce logic.
- Per-bit debounce, evaluated every rising clk edge:
  - If s2[i] == SW_clean[i]: cnt[i] goes to 0.
  - Else, if cnt[i] == STABLE_CYCLES-1: SW_clean[i] toggles and cnt[i] goes to 0.
  - Else: cnt[i] increments by 1.
- Latency: a clean, stable change on SW_raw[i] reaches SW_clean[i] exactly 2 + STABLE_CYCLES rising edges after the first edge that samples the new level.
- Glitch rejection: any return of s2[i] to the SW_clean[i] level before the count completes clears cnt[i]. SW_clean[i] does not change and no pulse is issued.
- Edge pulses:
  - SW_rise[i] and SW_fall[i] are registered and asserted for exactly one cycle, coincident with the cycle SW_clean[i] first shows its new value.
  - Both are never high together on the same bit.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous clean updates and pulses.
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- Reset mid-debounce discards all count progress.
- STABLE_CYCLES=1: SW_clean follows s2 with one extra register stage.

Decomposition:
- Shared package sw_pkg:
  - SW_WIDTH = 16
  - CLK_HZ = 100_000_000
  - DEBOUNCE_MS = 10
  - SIM_STABLE_CYCLES = 4
- Natural sub-module: debounce_bit.
  - Contents: one synchronizer pair, one counter, one clean flop and the rise/fall flops.
  - Instantiated WIDTH times by a generate loop in switch_debouncer.

Test Plan (STABLE_CYCLES=4, 10 ns clk):
1. Reset then idle: rst=1 for 3 cycles with SW_raw=16'h0000, then release → SW_clean=16'h0000 and rise/fall=0 for 20 cycles.
2. Clean step: SW_raw=16'h0001 held → SW_clean=16'h0001 exactly 6 edges later, and SW_rise=16'h0001 for that one cycle only.
3. Glitch: SW_raw[3] high for 3 cycles, then low → SW_clean stays 16'h0000 and no pulses. A 5-cycle pulse on SW_raw[3] does produce a rise, then a matching fall 6 edges after the low returns.
4. Walking one: SW_raw steps 16'h0001, 16'h0002 … 16'h8000, each held 10 cycles → SW_clean follows each value with 6-cycle lag; at each step one SW_fall and one SW_rise fire on the same cycle, on adjacent bits.
5. All bits: SW_raw 16'h0000 to 16'hFFFF → SW_clean=16'hFFFF and SW_rise=16'hFFFF on the same single cycle.
6. Reset mid-operation: SW_raw=16'hFFFF, assert rst asynchronously 3 cycles in → outputs drop to 0 immediately. After release, SW_clean=16'hFFFF arrives a full 6 edges later.
